// File: rtl/network_pkg.sv
// Shared types and helpers for the network core sequencer.
package network_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } sched_state_t;

  // Evaluation window: height * 2**(width+2) core cycles.
  function automatic int window_len(input int width, input int height);
    return height * (1 << (width + 2));
  endfunction

endpackage

// File: rtl/network_scheduler_spike_counter.sv
// Rising-edge detector on the core spike output feeding a saturating counter.
module spike_counter
  import network_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_spike,
  output logic [CNT_W-1:0] o_count
);

  logic             r_prev;
  logic [CNT_W-1:0] r_count;
  logic             w_rise;
  logic             w_sat;

  assign w_rise  = i_spike & ~r_prev;
  assign w_sat   = &r_count;
  assign o_count = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev  <= 1'b0;
      r_count <= '0;
    end else if (i_clr) begin
      r_prev  <= 1'b0;
      r_count <= '0;
    end else if (i_en) begin
      r_prev <= i_spike;
      if (w_rise && !w_sat) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/network_scheduler.sv
// Runs the spiking network core over one frame at a time: core reset, a fixed
// enabled window, then a spike-count result over a valid/ready port.
//
// state | meaning
// IDLE  | waiting for a frame, core held in reset
// LOAD  | one-cycle core reset, window and spike count cleared
// RUN   | core enabled for WINDOW cycles, spike edges counted
// DONE  | result presented until the sink accepts it
module network_scheduler
  import network_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HEIGHT      = 7,
  parameter int WINDOW      = window_len(WIDTH, HEIGHT),
  parameter int CNT_W       = 8,
  parameter int FIRE_THRESH = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_valid,
  output logic              o_frame_ready,
  input  logic [HEIGHT-1:0] i_frame_pixels,
  input  logic              i_abort,
  output logic              o_net_rst,
  output logic              o_net_en,
  output logic [HEIGHT-1:0] o_net_pixels,
  input  logic              i_net_spike,
  output logic              o_result_valid,
  input  logic              i_result_ready,
  output logic [CNT_W-1:0]  o_result_count,
  output logic              o_result_fire,
  output logic              o_busy
);

  localparam int                WIN_W  = $clog2(WINDOW + 1);
  localparam logic [WIN_W-1:0]  LAST   = WIN_W'(WINDOW - 1);
  localparam logic [31:0]       THRESH = 32'(FIRE_THRESH);

  sched_state_t      r_state;
  logic [WIN_W-1:0]  r_win;
  logic [HEIGHT-1:0] r_net_pixels;
  logic              r_net_en;
  logic              r_net_rst;
  logic              r_result_valid;
  logic              r_busy;
  logic [CNT_W-1:0]  w_count;
  logic              w_clr;
  logic              w_cnt_en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_win          <= '0;
      r_net_pixels   <= '0;
      r_net_en       <= 1'b0;
      r_net_rst      <= 1'b1;
      r_result_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_frame_valid) begin
            r_state      <= LOAD;
            r_net_pixels <= i_frame_pixels;
            r_busy       <= 1'b1;
          end
        end
        LOAD: begin
          r_win <= '0;
          if (i_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state   <= RUN;
            r_net_en  <= 1'b1;
            r_net_rst <= 1'b0;
          end
        end
        RUN: begin
          // Abort wins even on the final window cycle: no result is produced.
          if (i_abort) begin
            r_state   <= IDLE;
            r_net_en  <= 1'b0;
            r_net_rst <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_win <= r_win + 1'b1;
            if (r_win == LAST) begin
              r_state        <= DONE;
              r_net_en       <= 1'b0;
              r_net_rst      <= 1'b1;
              r_result_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (i_result_ready) begin
            r_state        <= IDLE;
            r_result_valid <= 1'b0;
            r_busy         <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign w_clr    = (r_state == LOAD);
  assign w_cnt_en = (r_state == RUN);

  spike_counter #(
    .CNT_W(CNT_W)
  ) u_spike_counter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (w_clr),
    .i_en   (w_cnt_en),
    .i_spike(i_net_spike),
    .o_count(w_count)
  );

  // The count only moves in RUN, so it is naturally frozen while DONE waits.
  assign o_frame_ready  = (r_state == IDLE);
  assign o_net_rst      = r_net_rst;
  assign o_net_en       = r_net_en;
  assign o_net_pixels   = r_net_pixels;
  assign o_result_valid = r_result_valid;
  assign o_result_count = w_count;
  assign o_result_fire  = (32'(w_count) >= THRESH);
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_network_scheduler.sv
// Randomized and directed bench for network_scheduler against a frame-level model.
module tb_network_scheduler;

  localparam int WIDTH       = 2;
  localparam int HEIGHT      = 2;
  localparam int CNT_W       = 4;
  localparam int FIRE_THRESH = 3;
  localparam int WINDOW      = 32;
  localparam int SAT         = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_frame_valid = 1'b0;
  logic              o_frame_ready;
  logic [HEIGHT-1:0] i_frame_pixels = '0;
  logic              i_abort = 1'b0;
  logic              o_net_rst;
  logic              o_net_en;
  logic [HEIGHT-1:0] o_net_pixels;
  logic              i_net_spike = 1'b0;
  logic              o_result_valid;
  logic              i_result_ready = 1'b0;
  logic [CNT_W-1:0]  o_result_count;
  logic              o_result_fire;
  logic              o_busy;

  always #5 clk = ~clk;

  network_scheduler #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CNT_W(CNT_W), .FIRE_THRESH(FIRE_THRESH)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_frame_valid(i_frame_valid), .o_frame_ready(o_frame_ready),
    .i_frame_pixels(i_frame_pixels), .i_abort(i_abort),
    .o_net_rst(o_net_rst), .o_net_en(o_net_en), .o_net_pixels(o_net_pixels),
    .i_net_spike(i_net_spike),
    .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
    .o_result_count(o_result_count), .o_result_fire(o_result_fire),
    .o_busy(o_busy)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: m_k counts edges since the accepting edge; edge 0 is the
  // core-reset cycle, edges 1..WINDOW are the enabled window.
  bit          m_busy = 0;
  bit          m_done = 0;
  int          m_k    = 0;
  logic [1:0]  m_pix  = '0;
  bit          m_samp [WINDOW];
  int          spike_mode = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0;
      m_done <= 0;
      m_k    <= 0;
      m_pix  <= '0;
    end else if (m_done) begin
      if (i_result_ready) m_done <= 0;
    end else if (m_busy) begin
      if (i_abort) begin
        m_busy <= 0;
      end else begin
        if (m_k >= 1) m_samp[m_k-1] <= i_net_spike;
        if (m_k == WINDOW) begin
          m_busy <= 0;
          m_done <= 1;
        end
        m_k <= m_k + 1;
      end
    end else if (i_frame_valid) begin
      m_busy <= 1;
      m_k    <= 0;
      m_pix  <= i_frame_pixels;
    end
  end

  function automatic int exp_count();
    int  c = 0;
    bit  prev = 0;
    for (int i = 0; i < WINDOW; i++) begin
      if (m_samp[i] && !prev) c++;
      prev = m_samp[i];
    end
    return (c > SAT) ? SAT : c;
  endfunction

  always @(negedge clk) begin
    bit run;
    int e;
    run = m_busy && (m_k >= 1);
    check("frame_ready", o_frame_ready, !m_busy && !m_done);
    check("busy", o_busy, m_busy || m_done);
    check("net_en", o_net_en, run);
    check("net_rst", o_net_rst, !run);
    check("result_valid", o_result_valid, m_done);
    check("net_pixels", o_net_pixels, m_pix);
    if (m_done) begin
      e = exp_count();
      check("result_count", o_result_count, e);
      check("result_fire", o_result_fire, e >= FIRE_THRESH);
    end
  end

  // Spike source: patterned inside the window, random noise outside it.
  initial begin
    forever begin
      int r;
      @(negedge clk);
      if (m_busy && m_k >= 1) begin
        r = m_k - 1;
        case (spike_mode)
          1:       i_net_spike = (r % 4 == 3);
          2:       i_net_spike = 1'b0;
          3:       i_net_spike = (r % 2 == 0);
          default: i_net_spike = 1'($urandom);
        endcase
      end else begin
        i_net_spike = 1'($urandom);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int n = 0;
    while ((m_busy || m_done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait_timeout", n >= 200, 0);
  endtask

  task automatic do_frame(input logic [1:0] pix, input int pat, input int hold, input int abort_k,
                          output int lat, output int en_cnt, output logic [3:0] cnt,
                          output logic fire, output logic got);
    spike_mode = pat;
    lat = -1; en_cnt = 0; cnt = '0; fire = 1'b0; got = 1'b0;
    wait_idle();
    i_frame_valid  = 1'b1;
    i_frame_pixels = pix;
    @(negedge clk);
    i_frame_valid  = 1'b0;
    i_frame_pixels = 2'($urandom);
    for (int n = 0; n < WINDOW + 10; n++) begin
      if (o_result_valid) begin
        lat = n + 1; cnt = o_result_count; fire = o_result_fire; got = 1'b1;
        break;
      end
      if (!m_busy) break;
      if (o_net_en) en_cnt++;
      i_abort = (abort_k >= 0) && (m_k == abort_k);
      @(negedge clk);
    end
    i_abort = 1'b0;
    if (got) begin
      for (int h = 0; h < hold; h++) begin
        i_result_ready = 1'b0;
        i_abort = 1'($urandom);
        @(negedge clk);
      end
      i_abort = 1'b0;
      i_result_ready = 1'b1;
      @(negedge clk);
      i_result_ready = 1'b0;
    end
  endtask

  initial begin
    int         lat, en_cnt, ak, n;
    logic [3:0] cnt;
    logic       fire, got, seen;

    repeat (3) @(negedge clk);
    check("rst_frame_ready", o_frame_ready, 1);
    check("rst_net_rst", o_net_rst, 1);
    check("rst_net_en", o_net_en, 0);
    check("rst_valid", o_result_valid, 0);
    check("rst_count", o_result_count, 0);
    check("rst_fire", o_result_fire, 0);
    check("rst_busy", o_busy, 0);
    check("rst_pixels", o_net_pixels, 0);
    rst = 1'b0;
    @(negedge clk);

    // single frame, spike every 4th window cycle
    do_frame(2'b11, 1, 0, -1, lat, en_cnt, cnt, fire, got);
    check("single_got", got, 1);
    check("single_latency", lat, 34);
    check("single_en_cycles", en_cnt, 32);
    check("single_count", cnt, 8);
    check("single_fire", fire, 1);
    check("single_pixels_held", o_net_pixels, 2'b11);

    do_frame(2'b01, 2, 1, -1, lat, en_cnt, cnt, fire, got);
    check("nospike_count", cnt, 0);
    check("nospike_fire", fire, 0);

    do_frame(2'b10, 3, 0, -1, lat, en_cnt, cnt, fire, got);
    check("sat_count", cnt, 15);
    check("sat_fire", fire, 1);

    // backpressure with a second frame waiting
    spike_mode = 1;
    wait_idle();
    i_frame_valid  = 1'b1;
    i_frame_pixels = 2'b01;
    @(negedge clk);
    i_frame_pixels = 2'b10;
    n = 0;
    while (!o_result_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_result_seen", o_result_valid, 1);
    for (int h = 0; h < 10; h++) begin
      check("bp_count_held", o_result_count, 8);
      check("bp_frame_ready", o_frame_ready, 0);
      @(negedge clk);
    end
    check("bp_pixels_not_taken", o_net_pixels, 2'b01);
    i_result_ready = 1'b1;
    @(negedge clk);
    i_result_ready = 1'b0;
    check("bp_idle_after_ready", o_frame_ready, 1);
    check("bp_valid_dropped", o_result_valid, 0);
    @(negedge clk);
    i_frame_valid = 1'b0;
    check("bp_second_busy", o_busy, 1);
    check("bp_second_pixels", o_net_pixels, 2'b10);
    n = 0;
    while (!o_result_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_second_result", o_result_count, 8);
    i_result_ready = 1'b1;
    @(negedge clk);
    i_result_ready = 1'b0;

    // abort at window cycle 12
    do_frame(2'b01, 1, 0, 13, lat, en_cnt, cnt, fire, got);
    check("abort_no_result", got, 0);
    check("abort_valid", o_result_valid, 0);
    check("abort_net_en", o_net_en, 0);
    check("abort_net_rst", o_net_rst, 1);
    check("abort_idle", o_frame_ready, 1);
    do_frame(2'b10, 1, 0, -1, lat, en_cnt, cnt, fire, got);
    check("post_abort_en_cycles", en_cnt, 32);
    check("post_abort_count", cnt, 8);

    // randomized frames, some aborted anywhere in LOAD or the window
    for (int i = 0; i < 12; i++) begin
      ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WINDOW)) : -1;
      do_frame(2'($urandom), 0, $urandom_range(0, 3), ak, lat, en_cnt, cnt, fire, got);
      check("rand_got", got, ak < 0);
    end

    // async reset in the middle of the window
    spike_mode = 0;
    wait_idle();
    i_frame_valid  = 1'b1;
    i_frame_pixels = 2'b11;
    @(negedge clk);
    i_frame_valid  = 1'b0;
    n = 0;
    while (m_k < 10 && n < 50) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1;
    check("arst_frame_ready", o_frame_ready, 1);
    check("arst_net_rst", o_net_rst, 1);
    check("arst_net_en", o_net_en, 0);
    check("arst_valid", o_result_valid, 0);
    check("arst_count", o_result_count, 0);
    check("arst_busy", o_busy, 0);
    check("arst_pixels", o_net_pixels, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (o_result_valid) seen = 1'b1;
    end
    check("arst_no_result", seen, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
